prg_sequencer: RTL

PRG_SEQUENCER -- requirements
Module: prg_sequencer

---
 rtl/prg_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/prg_sequencer.sv
// Purpose : sequences single/burst byte writes and reads onto a programmer memory port.
// Latency : first write beat one cycle after accept; read byte valid RD_LATENCY+2 cycles after accept.
// Backpres: one command in flight (cmd_ready only in IDLE); each read byte is held until rsp_ready.
//
// Ports:
//   clock, reset                          single clock, synchronous active-high reset
//   cmd_valid/cmd_ready                   command handshake
//   cmd_op (00 WR, 01 RD, 10 FILL, 11 DUMP), cmd_addr, cmd_len (bytes-1), cmd_data
//   rsp_valid/rsp_ready                   read-byte handshake with rsp_data/rsp_addr/rsp_last
//   busy                                  sequencer not idle
//   prg_we, prg_MA, prg_WD, prg_RD        programmer memory port (clocked by clock)
module prg_sequencer #(
    parameter int RD_LATENCY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_len,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [7:0] rsp_addr,
    output logic       rsp_last,
    output logic       busy,
    output logic       prg_we,
    output logic [7:0] prg_MA,
    output logic [7:0] prg_WD,
    input  logic [7:0] prg_RD
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR       = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_RSP      = 3'd4;

    logic [2:0] state;
    // Bytes still to transfer including the current one; 9 bits so a
    // 256-byte burst (cmd_len = 255) is representable.
    logic [8:0] remaining;
    // Extra RD_WAIT cycles still to spend before prg_RD is valid.
    logic       wait_cnt;
    logic       last_q;

    // Combinational outputs are masked by reset so that nothing is signalled
    // during the reset cycle itself, before the state register has cleared.
    assign cmd_ready = (state == S_IDLE) && !reset;
    assign busy      = (state != S_IDLE) && !reset;
    assign prg_we    = (state == S_WR) && !reset;
    assign rsp_valid = (state == S_RSP) && !reset;
    assign rsp_last  = rsp_valid && last_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= 9'd0;
            wait_cnt  <= 1'b0;
            last_q    <= 1'b0;
            prg_MA    <= 8'h00;
            prg_WD    <= 8'h00;
            rsp_data  <= 8'h00;
            rsp_addr  <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    // cmd_ready is high in IDLE, so cmd_valid alone is an accept.
                    if (cmd_valid) begin
                        prg_MA    <= cmd_addr;
                        // op[1] selects the burst forms; op[0] selects reads.
                        remaining <= cmd_op[1] ? ({1'b0, cmd_len} + 9'd1) : 9'd1;
                        if (!cmd_op[0]) begin
                            prg_WD <= cmd_data;
                            state  <= S_WR;
                        end else begin
                            state  <= S_RD_ISSUE;
                        end
                    end
                end
                S_WR: begin
                    if (remaining == 9'd1) begin
                        state <= S_IDLE;
                    end else begin
                        prg_MA    <= prg_MA + 8'd1;
                        remaining <= remaining - 9'd1;
                    end
                end
                S_RD_ISSUE: begin
                    wait_cnt <= (RD_LATENCY == 2);
                    state    <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (!wait_cnt) begin
                        rsp_data <= prg_RD;
                        rsp_addr <= prg_MA;
                        last_q   <= (remaining == 9'd1);
                        state    <= S_RSP;
                    end else begin
                        wait_cnt <= 1'b0;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        if (last_q) begin
                            state <= S_IDLE;
                        end else begin
                            prg_MA    <= prg_MA + 8'd1;
                            remaining <= remaining - 9'd1;
                            state     <= S_RD_ISSUE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
